// File: rtl/onboard_debug_pkg.sv
// -----------------------------------------------------------------------------
// onboard_debug_pkg
// Shared types and constants for the onboard-debug packet generator.
//   pkt_gen_state_e : generator state machine encoding
//   PAYLOAD_BASE    : index carried by the first word of every packet
// -----------------------------------------------------------------------------
package onboard_debug_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } pkt_gen_state_e;

    // Words are numbered from 1 so a sink-side word counter matches the data.
    localparam int unsigned PAYLOAD_BASE = 32'd1;

endpackage : onboard_debug_pkg

// File: rtl/avalon_st_pkt_gen.sv
// -----------------------------------------------------------------------------
// avalon_st_pkt_gen
// Avalon-ST source that emits a programmable burst of packets whose payload
// word equals its 1-based index within the packet.
//
// Ports:
//   clk            clock
//   rst_n          asynchronous reset, active-low
//   start          one-cycle burst request, sampled only while idle
//   pkt_len        words per packet (0 behaves as 1)
//   pkt_count      packets per burst (0 sends nothing)
//   gap_cycles     valid-low cycles inserted between packets
//   msg_out_valid  stream valid
//   msg_out_sop    start of packet
//   msg_out_eop    end of packet
//   msg_out_data   payload word (word index modulo 2^DATA_WIDTH)
//   msg_out_ready  downstream ready
//   busy           burst in progress (sending or in an inter-packet gap)
//   done           one-cycle pulse when the burst completes
//   pkts_sent      packets whose eop was accepted in the current/last burst
//
// All stream outputs come straight from flops, so ready never reaches valid
// combinationally.
// -----------------------------------------------------------------------------
module avalon_st_pkt_gen
    import onboard_debug_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [CNT_WIDTH-1:0]  pkt_count,
    input  logic [CNT_WIDTH-1:0]  gap_cycles,
    output logic                  msg_out_valid,
    output logic                  msg_out_sop,
    output logic                  msg_out_eop,
    output logic [DATA_WIDTH-1:0] msg_out_data,
    input  logic                  msg_out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  pkts_sent
);

    localparam logic [LEN_WIDTH-1:0] WORD_FIRST = LEN_WIDTH'(PAYLOAD_BASE);

    // A zero length is promoted to a single-word packet.
    function automatic logic [LEN_WIDTH-1:0] eff_len(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH-1:0] result;
        if (len == {LEN_WIDTH{1'b0}}) begin
            result = WORD_FIRST;
        end else begin
            result = len;
        end
        return result;
    endfunction

    pkt_gen_state_e        state_r, state_s;
    logic [LEN_WIDTH-1:0]  word_r, word_s;
    logic [LEN_WIDTH-1:0]  len_r, len_s;
    logic [CNT_WIDTH-1:0]  count_r, count_s;
    logic [CNT_WIDTH-1:0]  gap_r, gap_s;
    logic [CNT_WIDTH-1:0]  gap_cnt_r, gap_cnt_s;
    logic [CNT_WIDTH-1:0]  sent_r, sent_s;

    logic                  valid_r, valid_s;
    logic                  sop_r, sop_s;
    logic                  eop_r, eop_s;
    logic [DATA_WIDTH-1:0] data_r, data_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;

    // Next-state, counter and output-lookahead logic.
    always_comb begin
        state_s   = state_r;
        word_s    = word_r;
        len_s     = len_r;
        count_s   = count_r;
        gap_s     = gap_r;
        gap_cnt_s = gap_cnt_r;
        sent_s    = sent_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    len_s     = eff_len(pkt_len);
                    count_s   = pkt_count;
                    gap_s     = gap_cycles;
                    sent_s    = {CNT_WIDTH{1'b0}};
                    word_s    = WORD_FIRST;
                    gap_cnt_s = {CNT_WIDTH{1'b0}};
                    if (pkt_count == {CNT_WIDTH{1'b0}}) begin
                        state_s = FINISH;
                    end else begin
                        state_s = SEND;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (valid_r && msg_out_ready) begin
                    if (word_r == len_r) begin
                        sent_s = sent_r + CNT_WIDTH'(1);
                        word_s = WORD_FIRST;
                        if (sent_s == count_r) begin
                            state_s = FINISH;
                        end else if (gap_r == {CNT_WIDTH{1'b0}}) begin
                            state_s = SEND;
                        end else begin
                            state_s   = GAP;
                            gap_cnt_s = gap_r;
                        end
                    end else begin
                        word_s = word_r + LEN_WIDTH'(1);
                    end
                end else begin
                    // Stalled: everything holds so the presented beat is stable.
                    state_s = SEND;
                end
            end
            GAP: begin
                // Counter is loaded with gap_cycles, so leaving at 1 gives exactly that many cycles.
                if (gap_cnt_r <= CNT_WIDTH'(1)) begin
                    state_s = SEND;
                    word_s  = WORD_FIRST;
                end else begin
                    gap_cnt_s = gap_cnt_r - CNT_WIDTH'(1);
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Outputs are computed from next state so they can be registered without extra latency.
        valid_s = (state_s == SEND);
        sop_s   = valid_s && (word_s == WORD_FIRST);
        eop_s   = valid_s && (word_s == len_s);
        if (valid_s) begin
            data_s = DATA_WIDTH'(word_s);
        end else begin
            data_s = {DATA_WIDTH{1'b0}};
        end
        busy_s  = (state_s == SEND) || (state_s == GAP);
        done_s  = (state_s == FINISH);
    end

    // State, configuration and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            word_r    <= {LEN_WIDTH{1'b0}};
            len_r     <= {LEN_WIDTH{1'b0}};
            count_r   <= {CNT_WIDTH{1'b0}};
            gap_r     <= {CNT_WIDTH{1'b0}};
            gap_cnt_r <= {CNT_WIDTH{1'b0}};
            sent_r    <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r   <= state_s;
            word_r    <= word_s;
            len_r     <= len_s;
            count_r   <= count_s;
            gap_r     <= gap_s;
            gap_cnt_r <= gap_cnt_s;
            sent_r    <= sent_s;
        end
    end

    // Registered stream and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            sop_r   <= 1'b0;
            eop_r   <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            valid_r <= valid_s;
            sop_r   <= sop_s;
            eop_r   <= eop_s;
            data_r  <= data_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign msg_out_valid = valid_r;
    assign msg_out_sop   = sop_r;
    assign msg_out_eop   = eop_r;
    assign msg_out_data  = data_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pkts_sent     = sent_r;

endmodule : avalon_st_pkt_gen
